// File: rtl/demux_serial_paralelo.sv
// ---------------------------------------------------------------------------
// demux_serial_paralelo
//
// Receive end of a 4:1 MUX data path. The block steps the select lines of a
// remote MUX through every channel. It reads the MUX output back as a serial
// bit stream and rebuilds the parallel word that sits on the MUX inputs.
// The block dwells CICLOS_POR_CANAL clocks on each channel so the remote MUX
// has time to settle. It samples Y only on the last clock of each dwell.
// After the last channel it publishes the full word with a one-cycle pulse.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - synchronous reset, active-high, has priority over everything
//   en     - scan enable; low returns the block to idle and aborts a frame
//   Y      - serial bit read back from the remote MUX output
//   S      - registered channel select driving the remote MUX
//   D      - last complete rebuilt word (holds across aborts)
//   valid  - one-cycle pulse on every update of D
// ---------------------------------------------------------------------------
module demux_serial_paralelo #(
  parameter int N_CANAIS         = 4,
  parameter int SEL_W            = 2,
  parameter int CICLOS_POR_CANAL = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                Y,
  output logic [SEL_W-1:0]    S,
  output logic [N_CANAIS-1:0] D,
  output logic                valid
);

  localparam int DCNT_W = $clog2(CICLOS_POR_CANAL) + 1;

  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(CICLOS_POR_CANAL - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_CANAIS - 1);

  typedef enum logic {
    OCIOSO,
    VARRE
  } estado_t;

  estado_t             estado_q;
  logic [DCNT_W-1:0]   dcnt_q;
  logic [N_CANAIS-1:0] sh_q;
  logic [SEL_W-1:0]    sel_q;
  logic [N_CANAIS-1:0] d_q;
  logic                valid_q;

  logic [SEL_W-1:0]    sel_d;
  logic [N_CANAIS-1:0] word_d;

  // Next channel, wrapping after the last one. This also covers a channel
  // count that is not a power of two.
  // The published word is the shadow register with its top bit replaced by
  // the Y sampled on this edge. The last channel's bit never has to pass
  // through sh_q before it reaches D.
  always_comb begin
    sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
    word_d = sh_q;
    word_d[N_CANAIS-1] = Y;
  end

  // Scan FSM with registered outputs. In VARRE the dwell counter runs from
  // 0 to CICLOS_POR_CANAL-1. Its terminal count is the only edge that samples
  // Y and advances S. Dropping en throws away the partial frame, but the last
  // complete word stays on D.
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= OCIOSO;
      dcnt_q   <= '0;
      sh_q     <= '0;
      sel_q    <= '0;
      d_q      <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          dcnt_q  <= '0;
          sh_q    <= '0;
          sel_q   <= '0;
          valid_q <= 1'b0;
          if (en) begin
            estado_q <= VARRE;
          end
        end
        VARRE: begin
          if (!en) begin
            estado_q <= OCIOSO;
            dcnt_q   <= '0;
            sh_q     <= '0;
            sel_q    <= '0;
            valid_q  <= 1'b0;
          end else if (dcnt_q != DCNT_LAST) begin
            dcnt_q  <= dcnt_q + DCNT_W'(1);
            valid_q <= 1'b0;
          end else begin
            sh_q[sel_q] <= Y;
            dcnt_q      <= '0;
            sel_q       <= sel_d;
            if (sel_q == SEL_LAST) begin
              d_q     <= word_d;
              valid_q <= 1'b1;
            end else begin
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          estado_q <= OCIOSO;
          dcnt_q   <= '0;
          sh_q     <= '0;
          sel_q    <= '0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign S     = sel_q;
  assign D     = d_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_demux_serial_paralelo.sv
// ---------------------------------------------------------------------------
// tb_demux_serial_paralelo
//
// Drives two instances of demux_serial_paralelo side by side. One instance
// uses the default dwell of 20 clocks. The other uses a dwell of 1 clock.
// Each instance's Y comes from a modelled remote MUX, Y = src[S]. Between
// clock edges Y is replaced with random noise and then restored before the
// next edge. A time-based reference model predicts S, D and valid after
// every edge.
// ---------------------------------------------------------------------------
module tb_demux_serial_paralelo;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en0, y0, en1, y1;
  logic [1:0] s0, s1;
  logic [3:0] d0, d1;
  logic       v0, v1;

  demux_serial_paralelo #(.N_CANAIS(4), .SEL_W(2), .CICLOS_POR_CANAL(20)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .Y(y0), .S(s0), .D(d0), .valid(v0)
  );

  demux_serial_paralelo #(.N_CANAIS(4), .SEL_W(2), .CICLOS_POR_CANAL(1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .Y(y1), .S(s1), .D(d1), .valid(v1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model. mT counts the edges since the scan began. The channel,
  // the sample points and the frame boundaries are all derived from mT by
  // division.
  int         mC [2] = '{20, 1};
  bit         mAct [2];
  int         mT [2];
  int         mS [2];
  logic [3:0] mD [2];
  logic       mV [2];
  logic [3:0] mCap [2];

  logic [3:0] src0, src1;

  task automatic checkOutput1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input int k, input logic e, input logic y);
    int ch;
    if (rst) begin
      mAct[k] = 0; mT[k] = 0; mS[k] = 0; mD[k] = '0; mV[k] = 1'b0; mCap[k] = '0;
    end else if (!mAct[k]) begin
      mV[k] = 1'b0; mS[k] = 0;
      if (e) begin
        mAct[k] = 1; mT[k] = 0;
      end
    end else if (!e) begin
      mAct[k] = 0; mS[k] = 0; mV[k] = 1'b0;
    end else begin
      mT[k]++;
      mV[k] = 1'b0;
      if (mT[k] % mC[k] == 0) begin
        ch = (mT[k] / mC[k] - 1) % N;
        mCap[k][ch] = y;
        if (ch == N - 1) begin
          mD[k] = mCap[k];
          mV[k] = 1'b1;
        end
      end
      mS[k] = (mT[k] / mC[k]) % N;
    end
  endtask

  task automatic checkOutput();
    checkOutput1("S0", 32'(s0), 32'(mS[0]));
    checkOutput1("valid0", 32'(v0), 32'(mV[0]));
    checkOutput1("D0", 32'(d0), 32'(mD[0]));
    checkOutput1("S1", 32'(s1), 32'(mS[1]));
    checkOutput1("valid1", 32'(v1), 32'(mV[1]));
    checkOutput1("D1", 32'(d1), 32'(mD[1]));
  endtask

  // One clock. The model advances and the outputs are checked just after the
  // edge. Y then carries random noise for a few ns, and then settles to the
  // value the remote MUX would give for the current select.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge(0, en0, y0);
    modelEdge(1, en1, y1);
    #1;
    checkOutput();
    y0 = 1'($urandom);
    y1 = 1'($urandom);
    #3;
    y0 = src0[mS[0]];
    y1 = src1[mS[1]];
  endtask

  task automatic runUntilValid0(output int n);
    n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!v0 && n < 200);
  endtask

  int n;

  initial begin
    src0 = 4'b1010;
    src1 = 4'b1100;
    rst = 1'b1; en0 = 1'b1; en1 = 1'b1; y0 = 1'b1; y1 = 1'b1;

    applyStimulus();
    applyStimulus();
    checkOutput1("rstS", 32'(s0), 0);
    checkOutput1("rstD", 32'(d0), 0);
    checkOutput1("rstValid", 32'(v0), 0);

    rst = 1'b0;
    en0 = 1'b0; en1 = 1'b0;
    applyStimulus();
    en0 = 1'b1; en1 = 1'b1;
    runUntilValid0(n);
    checkOutput1("latency1", 32'(n - 1), 80);
    checkOutput1("frame1D", 32'(d0), 32'h0A);
    checkOutput1("fast1D", 32'(d1), 32'hC);

    for (int i = 0; i < 40; i++) applyStimulus();
    src0 = 4'b0101;
    n = 40;
    do begin
      applyStimulus();
      n++;
    end while (!v0 && n < 200);
    checkOutput1("gap2", 32'(n), 80);
    checkOutput1("frame2D", 32'(d0), 32'h6);
    applyStimulus();
    checkOutput1("pulseWidth", 32'(v0), 0);
    n = 1;
    do begin
      applyStimulus();
      n++;
    end while (!v0 && n < 200);
    checkOutput1("gap3", 32'(n), 80);
    checkOutput1("frame3D", 32'(d0), 32'h5);

    src0 = 4'b1010;
    runUntilValid0(n);
    checkOutput1("frame4D", 32'(d0), 32'hA);

    n = 0;
    while (mS[0] != 2 && n < 200) begin
      applyStimulus();
      n++;
    end
    for (int i = 0; i < 7; i++) applyStimulus();
    en0 = 1'b0;
    applyStimulus();
    checkOutput1("abortS", 32'(s0), 0);
    checkOutput1("abortD", 32'(d0), 32'hA);
    checkOutput1("abortValid", 32'(v0), 0);
    for (int i = 0; i < 90; i++) applyStimulus();
    checkOutput1("abortHoldD", 32'(d0), 32'hA);
    src0 = 4'($urandom);
    en0 = 1'b1;
    runUntilValid0(n);
    checkOutput1("reenterLatency", 32'(n - 1), 80);
    checkOutput1("reenterD", 32'(d0), 32'(src0));

    n = 0;
    while (mS[0] != 1 && n < 200) begin
      applyStimulus();
      n++;
    end
    for (int i = 0; i < 3; i++) applyStimulus();
    rst = 1'b1;
    applyStimulus();
    checkOutput1("midRstS", 32'(s0), 0);
    checkOutput1("midRstD", 32'(d0), 0);
    checkOutput1("midRstValid", 32'(v0), 0);
    rst = 1'b0;
    src0 = 4'($urandom);
    runUntilValid0(n);
    checkOutput1("postRstLatency", 32'(n - 1), 80);
    checkOutput1("postRstD", 32'(d0), 32'(src0));

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) en0 = ~en0;
      if ($urandom_range(0, 19) == 0) en1 = ~en1;
      if ($urandom_range(0, 99) == 0) src0 = 4'($urandom);
      if ($urandom_range(0, 9) == 0) src1 = 4'($urandom);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
